// File: rtl/iaoq_prefetch_queue_pkg.sv
// Shared fetch-path constants for the PA-RISC instruction prefetch queue.
package iaoq_prefetch_queue_pkg;

    localparam int          INST_W_DEF = 32;
    localparam int          PC_W_DEF   = 32;
    localparam int          PC_STEP    = 4;
    localparam logic [31:0] NOP_INST   = 32'h0800_0240;  // OR r0,r0,r0

endpackage

// File: rtl/iaoq_queue_ram.sv
// Entry storage for the prefetch queue: one write port, one async read port, no reset.
module iaoq_queue_ram
    import iaoq_prefetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = INST_W_DEF + PC_W_DEF,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iaoq_prefetch_queue.sv
// Fetch PC owner and circular {inst, pc} prefetch queue feeding IF/ID, with
// redirect flush and PA-RISC nullification of the next instruction.
module iaoq_prefetch_queue
    import iaoq_prefetch_queue_pkg::*;
#(
    parameter int              INST_W   = INST_W_DEF,
    parameter int              PC_W     = PC_W_DEF,
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              imem_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_target,
    input  logic              nullify,
    input  logic              deq_ready,
    output logic              deq_valid,
    output logic [INST_W-1:0] deq_inst,
    output logic [PC_W-1:0]   deq_pc,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               ENT_W   = INST_W + PC_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PC_W-1:0]  fpc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             null_pend;
    logic             pop;
    logic             enq;
    logic             null_eff;
    logic             wr_en;
    logic [ENT_W-1:0] rd_ent;
    logic             unused_tgt_lo;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign pop      = !empty && (deq_ready || nullify);
    // A full queue still accepts a fetch when the head leaves the same cycle.
    assign enq      = imem_ready && (!full || pop);
    // Nullify on an empty queue targets the next fetched entry, even this cycle's.
    assign null_eff = null_pend || (nullify && empty);
    assign wr_en    = enq && !null_eff && !redirect && !reset;

    assign unused_tgt_lo = ^redirect_target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc       <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            null_pend <= 1'b0;
        end else if (redirect) begin
            fpc       <= {redirect_target[PC_W-1:2], 2'b00};
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            null_pend <= 1'b0;
        end else begin
            if (enq) begin
                fpc       <= fpc + PC_W'(PC_STEP);
                null_pend <= 1'b0;
            end else begin
                null_pend <= null_eff;
            end
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    iaoq_queue_ram #(
        .DEPTH    (DEPTH),
        .WIDTH    (ENT_W),
        .ADDR_BITS(PTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(tail),
        .wdata({imem_data, fpc}),
        .raddr(head),
        .rdata(rd_ent)
    );

    assign imem_addr = fpc[ADDR_W-1:0];
    assign deq_valid = !empty;
    assign deq_inst  = empty ? '0 : rd_ent[ENT_W-1:PC_W];
    assign deq_pc    = empty ? '0 : rd_ent[PC_W-1:0];

endmodule
